acondicionador_botones: RTL and testbench

- Upstream front end of the PWM controller. Conditions the three raw pushbuttons (increase, decrease, option select) before they reach the control logic and the up/down counters.
- Each channel is synchronised, debounced and converted into single-cycle press pulses.
- The increase and decrease channels also auto-repeat while held, so the current/frequency setpoints can be slewed without repeated presses.

---
 rtl/dpwm_pkg.sv | 29 ++
 rtl/canal_boton.sv | 116 +++++++++++
 rtl/acondicionador_botones.sv | 88 ++++++++
 tb/tb_acondicionador_botones.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dpwm_pkg.sv
// -----------------------------------------------------------------------------
// dpwm_pkg
// Shared definitions for the pushbutton front end of the PWM controller.
//   - canal_estado_t : per-channel debounce state machine encoding
//   - *_DEF          : board-level timing defaults (100 MHz clock)
//   - ancho_contador : counter width needed to hold a given maximum count
// Keeping the timing defaults here lets the board build and any reduced
// simulation build pick their values from a single place.
// -----------------------------------------------------------------------------
package dpwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEB_PRESS = 2'd1,
        HELD      = 2'd2,
        DEB_REL   = 2'd3
    } canal_estado_t;

    // 5 ms debounce, 500 ms first repeat, 100 ms repeat period at 100 MHz
    localparam int unsigned DEB_CYCLES_DEF = 500000;
    localparam int unsigned REP_DELAY_DEF  = 50000000;
    localparam int unsigned REP_PERIOD_DEF = 10000000;

    // One spare bit above $clog2 so the maximum value itself always fits
    function automatic int unsigned ancho_contador(input int unsigned max_cuenta);
        return $clog2(max_cuenta) + 1;
    endfunction

endpackage

// File: rtl/canal_boton.sv
// -----------------------------------------------------------------------------
// canal_boton
// One conditioned pushbutton channel: two-flop synchroniser, debounce FSM
// and, when REPEAT_EN is set, an auto-repeat generator while the button is
// held. Produces a registered single-cycle press pulse.
// Ports:
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   boton  : raw asynchronous button level, active high
//   pulso  : one-cycle pulse per accepted press / auto-repeat step
// -----------------------------------------------------------------------------
module canal_boton
    import dpwm_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
    parameter int unsigned REP_PERIOD = REP_PERIOD_DEF,
    parameter bit          REPEAT_EN  = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic boton,
    output logic pulso
);

    localparam int unsigned DEB_W   = ancho_contador(DEB_CYCLES);
    localparam int unsigned REP_MAX = REP_DELAY + REP_PERIOD;
    localparam int unsigned REP_W   = ancho_contador(REP_MAX);

    localparam logic [DEB_W-1:0] DEB_UNO = DEB_W'(1);
    localparam logic [DEB_W-1:0] DEB_FIN = DEB_W'(DEB_CYCLES);
    localparam logic [REP_W-1:0] REP_UNO = REP_W'(1);
    localparam logic [REP_W-1:0] REP_INI = REP_W'(REP_DELAY);
    localparam logic [REP_W-1:0] REP_FIN = REP_W'(REP_MAX);

    logic                sync_a;
    logic                sync_s;
    canal_estado_t       estado;
    logic [DEB_W-1:0]    cuenta_deb;
    logic [REP_W-1:0]    cuenta_rep;
    logic [REP_W-1:0]    rep_sig;

    // Two-flop synchroniser; the FSM only ever looks at sync_s
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_s <= 1'b0;
        end else begin
            sync_a <= boton;
            sync_s <= sync_a;
        end
    end

    always_comb rep_sig = cuenta_rep + REP_UNO;

    // Debounce / hold FSM with registered pulse output.
    // The repeat counter runs from 0 up to REP_DELAY+REP_PERIOD and then
    // folds back to REP_DELAY, so it never needs more range than that window;
    // a pulse fires at both REP_DELAY and the fold point.
    // A short release glitch (DEB_REL back to HELD) leaves the repeat counter
    // untouched so the repeat schedule simply resumes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado     <= IDLE;
            cuenta_deb <= '0;
            cuenta_rep <= '0;
            pulso      <= 1'b0;
        end else begin
            pulso <= 1'b0;
            case (estado)
                IDLE: begin
                    if (sync_s) begin
                        estado     <= DEB_PRESS;
                        cuenta_deb <= DEB_UNO;
                    end
                end
                DEB_PRESS: begin
                    if (!sync_s) begin
                        estado <= IDLE;
                    end else if (cuenta_deb == DEB_FIN) begin
                        estado     <= HELD;
                        cuenta_rep <= '0;
                        pulso      <= 1'b1;
                    end else begin
                        cuenta_deb <= cuenta_deb + DEB_UNO;
                    end
                end
                HELD: begin
                    if (!sync_s) begin
                        estado     <= DEB_REL;
                        cuenta_deb <= DEB_UNO;
                    end else if (REPEAT_EN) begin
                        if ((rep_sig == REP_INI) || (rep_sig == REP_FIN)) begin
                            pulso <= 1'b1;
                        end
                        cuenta_rep <= (rep_sig == REP_FIN) ? REP_INI : rep_sig;
                    end
                end
                DEB_REL: begin
                    if (sync_s) begin
                        estado <= HELD;
                    end else if (cuenta_deb == DEB_FIN) begin
                        estado     <= IDLE;
                        cuenta_rep <= '0;
                    end else begin
                        cuenta_deb <= cuenta_deb + DEB_UNO;
                    end
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/acondicionador_botones.sv
// -----------------------------------------------------------------------------
// acondicionador_botones
// Front end for the three raw pushbuttons of the PWM controller. Each button
// is conditioned by a canal_boton instance; increase/decrease auto-repeat,
// option select does not. Increase and decrease pulses that land on the same
// cycle cancel each other.
// Ports:
//   clk        : system clock (100 MHz)
//   reset      : asynchronous active-low reset
//   aumentar   : raw increase button, active high
//   disminuir  : raw decrease button, active high
//   seleccion  : raw option button, active high
//   au         : one-cycle increase pulse
//   dis        : one-cycle decrease pulse
//   sel        : one-cycle option pulse
// -----------------------------------------------------------------------------
module acondicionador_botones
    import dpwm_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int unsigned REP_DELAY  = REP_DELAY_DEF,
    parameter int unsigned REP_PERIOD = REP_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic aumentar,
    input  logic disminuir,
    input  logic seleccion,
    output logic au,
    output logic dis,
    output logic sel
);

    logic raw_au;
    logic raw_dis;
    logic raw_sel;

    canal_boton #(
        .DEB_CYCLES (DEB_CYCLES),
        .REP_DELAY  (REP_DELAY),
        .REP_PERIOD (REP_PERIOD),
        .REPEAT_EN  (1'b1)
    ) u_canal_au (
        .clk   (clk),
        .reset (reset),
        .boton (aumentar),
        .pulso (raw_au)
    );

    canal_boton #(
        .DEB_CYCLES (DEB_CYCLES),
        .REP_DELAY  (REP_DELAY),
        .REP_PERIOD (REP_PERIOD),
        .REPEAT_EN  (1'b1)
    ) u_canal_dis (
        .clk   (clk),
        .reset (reset),
        .boton (disminuir),
        .pulso (raw_dis)
    );

    canal_boton #(
        .DEB_CYCLES (DEB_CYCLES),
        .REP_DELAY  (REP_DELAY),
        .REP_PERIOD (REP_PERIOD),
        .REPEAT_EN  (1'b0)
    ) u_canal_sel (
        .clk   (clk),
        .reset (reset),
        .boton (seleccion),
        .pulso (raw_sel)
    );

    // Output registers; coincident increase/decrease requests are ambiguous,
    // so both are dropped rather than letting one win
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            au  <= 1'b0;
            dis <= 1'b0;
            sel <= 1'b0;
        end else begin
            au  <= raw_au & ~raw_dis;
            dis <= raw_dis & ~raw_au;
            sel <= raw_sel;
        end
    end

endmodule

// File: tb/tb_acondicionador_botones.sv
// -----------------------------------------------------------------------------
// tb_acondicionador_botones
// Self-checking bench for acondicionador_botones with reduced timing
// (DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8). A run-length based reference
// model tracks the expected outputs; directed scenarios also check their
// pulse schedules against fixed edge numbers.
// -----------------------------------------------------------------------------
module tb_acondicionador_botones;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic clk       = 1'b0;
    logic reset     = 1'b0;
    logic aumentar  = 1'b0;
    logic disminuir = 1'b0;
    logic seleccion = 1'b0;
    logic au;
    logic dis;
    logic sel;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    acondicionador_botones #(
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RD),
        .REP_PERIOD (RP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .aumentar  (aumentar),
        .disminuir (disminuir),
        .seleccion (seleccion),
        .au        (au),
        .dis       (dis),
        .sel       (sel)
    );

    // Reference model: the button seen by the logic is the pin two edges
    // late. The accepted level flips once DEB+1 consecutive samples disagree
    // with it. Held time grows on every edge where the accepted level is high
    // and the button was high on this and the previous sample; repeat pulses
    // fall at held time RD, RD+RP, RD+2*RP, ... Output is one edge later.
    logic [2:0] m_d1;
    logic [2:0] m_d2;
    logic [2:0] m_sprev;
    logic [2:0] m_level;
    logic [2:0] m_raw;
    int         m_run  [3];
    int         m_held [3];
    logic       exp_au;
    logic       exp_dis;
    logic       exp_sel;

    always @(posedge clk or negedge reset) begin : modelo
        logic [2:0] pins;
        logic [2:0] pulse;
        logic       s;
        if (!reset) begin
            m_d1    <= '0;
            m_d2    <= '0;
            m_raw   <= '0;
            m_sprev = '0;
            m_level = '0;
            for (int c = 0; c < 3; c++) begin
                m_run[c]  = 0;
                m_held[c] = 0;
            end
            exp_au  <= 1'b0;
            exp_dis <= 1'b0;
            exp_sel <= 1'b0;
        end else begin
            exp_au  <= m_raw[0] & ~m_raw[1];
            exp_dis <= m_raw[1] & ~m_raw[0];
            exp_sel <= m_raw[2];
            pins  = {seleccion, disminuir, aumentar};
            pulse = '0;
            for (int c = 0; c < 3; c++) begin
                s = m_d2[c];
                if (s != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DEB + 1) begin
                        m_level[c] = s;
                        m_run[c]   = 0;
                        m_held[c]  = 0;
                        pulse[c]   = s;
                    end
                end else begin
                    m_run[c] = 0;
                    if (c != 2 && s && m_sprev[c]) begin
                        m_held[c]++;
                        if (m_held[c] == RD ||
                            (m_held[c] > RD && ((m_held[c] - RD) % RP) == 0)) begin
                            pulse[c] = 1'b1;
                        end
                    end
                end
                m_sprev[c] = s;
            end
            m_raw <= pulse;
            m_d2  <= m_d1;
            m_d1  <= pins;
        end
    end

    // Drive one set of pin levels and let one active edge sample them;
    // returns 1 time unit after that edge so outputs can be read safely
    task automatic advance(input logic a, input logic d, input logic s);
        aumentar  = a;
        disminuir = d;
        seleccion = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        advance(1'b0, 1'b0, 1'b0);
        advance(1'b0, 1'b0, 1'b0);
        if ({au, dis, sel} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_state: outputs=%b expected=000", {au, dis, sel});
        end
        checks++;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            advance(1'b0, 1'b0, 1'b0);
            if ({au, dis, sel} !== {exp_au, exp_dis, exp_sel}) begin
                errors++;
                $display("[TB] FAIL reset_idle cycle %0d: outputs=%b expected=%b",
                         i, {au, dis, sel}, {exp_au, exp_dis, exp_sel});
            end
            checks++;
        end
    endtask

    task automatic test_clean_press();
        int q_au[$];
        int others = 0;
        for (int i = 0; i < 30; i++) begin
            advance(i < 10, 1'b0, 1'b0);
            if ({au, dis, sel} !== {exp_au, exp_dis, exp_sel}) begin
                errors++;
                $display("[TB] FAIL clean_press cycle %0d: outputs=%b expected=%b",
                         i, {au, dis, sel}, {exp_au, exp_dis, exp_sel});
            end
            checks++;
            if (au === 1'b1) q_au.push_back(i);
            if (dis !== 1'b0 || sel !== 1'b0) others++;
        end
        if (q_au.size() != 1 || q_au[0] != 7) begin
            errors++;
            $display("[TB] FAIL clean_press_schedule: au pulses=%0d first=%0d expected 1 pulse at edge 7",
                     q_au.size(), (q_au.size() > 0) ? q_au[0] : -1);
        end
        checks++;
        if (others != 0) begin
            errors++;
            $display("[TB] FAIL clean_press_quiet: dis/sel active cycles=%0d expected=0", others);
        end
        checks++;
    endtask

    task automatic test_bounce();
        logic [5:0] patron = 6'b101101;
        int q_au[$];
        logic a;
        for (int i = 0; i < 35; i++) begin
            a = (i < 6) ? patron[5 - i] : (i < 16);
            advance(a, 1'b0, 1'b0);
            if ({au, dis, sel} !== {exp_au, exp_dis, exp_sel}) begin
                errors++;
                $display("[TB] FAIL bounce cycle %0d: outputs=%b expected=%b",
                         i, {au, dis, sel}, {exp_au, exp_dis, exp_sel});
            end
            checks++;
            if (au === 1'b1) q_au.push_back(i);
        end
        if (q_au.size() != 1 || q_au[0] != 12) begin
            errors++;
            $display("[TB] FAIL bounce_schedule: au pulses=%0d first=%0d expected 1 pulse at edge 12",
                     q_au.size(), (q_au.size() > 0) ? q_au[0] : -1);
        end
        checks++;
    endtask

    task automatic test_auto_repeat();
        int exp_edges[6] = '{7, 27, 35, 43, 51, 59};
        int q_dis[$];
        int q_sel[$];
        int au_count = 0;
        for (int i = 0; i < 80; i++) begin
            advance(1'b0, i < 60, i < 60);
            if ({au, dis, sel} !== {exp_au, exp_dis, exp_sel}) begin
                errors++;
                $display("[TB] FAIL auto_repeat cycle %0d: outputs=%b expected=%b",
                         i, {au, dis, sel}, {exp_au, exp_dis, exp_sel});
            end
            checks++;
            if (dis === 1'b1) q_dis.push_back(i);
            if (sel === 1'b1) q_sel.push_back(i);
            if (au !== 1'b0) au_count++;
        end
        if (q_dis.size() != 6) begin
            errors++;
            $display("[TB] FAIL auto_repeat_count: dis pulses=%0d expected=6", q_dis.size());
        end
        checks++;
        for (int k = 0; k < 6; k++) begin
            if (((k < q_dis.size()) ? q_dis[k] : -1) != exp_edges[k]) begin
                errors++;
                $display("[TB] FAIL auto_repeat_edge%0d: dis pulse at %0d expected %0d",
                         k, (k < q_dis.size()) ? q_dis[k] : -1, exp_edges[k]);
            end
            checks++;
        end
        if (q_sel.size() != 1 || q_sel[0] != 7) begin
            errors++;
            $display("[TB] FAIL sel_no_repeat: sel pulses=%0d expected 1 pulse at edge 7", q_sel.size());
        end
        checks++;
        if (au_count != 0) begin
            errors++;
            $display("[TB] FAIL auto_repeat_au_quiet: au active cycles=%0d expected=0", au_count);
        end
        checks++;
    endtask

    task automatic test_simultaneous();
        int ud_count = 0;
        int q_sel[$];
        for (int i = 0; i < 30; i++) begin
            advance(i < 10, i < 10, i < 10);
            if ({au, dis, sel} !== {exp_au, exp_dis, exp_sel}) begin
                errors++;
                $display("[TB] FAIL simultaneous cycle %0d: outputs=%b expected=%b",
                         i, {au, dis, sel}, {exp_au, exp_dis, exp_sel});
            end
            checks++;
            if (au !== 1'b0 || dis !== 1'b0) ud_count++;
            if (sel === 1'b1) q_sel.push_back(i);
        end
        if (ud_count != 0) begin
            errors++;
            $display("[TB] FAIL simultaneous_drop: au/dis active cycles=%0d expected=0", ud_count);
        end
        checks++;
        if (q_sel.size() != 1 || q_sel[0] != 7) begin
            errors++;
            $display("[TB] FAIL simultaneous_sel: sel pulses=%0d expected 1 pulse at edge 7", q_sel.size());
        end
        checks++;
    endtask

    task automatic test_release_glitch();
        int exp_edges[3] = '{7, 27, 38};
        int q_au[$];
        logic a;
        for (int i = 0; i < 60; i++) begin
            a = (i < 30) || (i >= 32 && i < 42);
            advance(a, 1'b0, 1'b0);
            if ({au, dis, sel} !== {exp_au, exp_dis, exp_sel}) begin
                errors++;
                $display("[TB] FAIL release_glitch cycle %0d: outputs=%b expected=%b",
                         i, {au, dis, sel}, {exp_au, exp_dis, exp_sel});
            end
            checks++;
            if (au === 1'b1) q_au.push_back(i);
        end
        if (q_au.size() != 3) begin
            errors++;
            $display("[TB] FAIL release_glitch_count: au pulses=%0d expected=3", q_au.size());
        end
        checks++;
        for (int k = 0; k < 3; k++) begin
            if (((k < q_au.size()) ? q_au[k] : -1) != exp_edges[k]) begin
                errors++;
                $display("[TB] FAIL release_glitch_edge%0d: au pulse at %0d expected %0d",
                         k, (k < q_au.size()) ? q_au[k] : -1, exp_edges[k]);
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid();
        int q_au[$];
        for (int i = 0; i < 4; i++) begin
            advance(1'b1, 1'b0, 1'b0);
            if ({au, dis, sel} !== {exp_au, exp_dis, exp_sel}) begin
                errors++;
                $display("[TB] FAIL reset_mid_press cycle %0d: outputs=%b expected=%b",
                         i, {au, dis, sel}, {exp_au, exp_dis, exp_sel});
            end
            checks++;
        end
        reset = 1'b0;
        #1;
        if ({au, dis, sel} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_mid_async: outputs=%b expected=000", {au, dis, sel});
        end
        checks++;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            advance(1'b1, 1'b0, 1'b0);
            if ({au, dis, sel} !== {exp_au, exp_dis, exp_sel}) begin
                errors++;
                $display("[TB] FAIL reset_release cycle %0d: outputs=%b expected=%b",
                         i, {au, dis, sel}, {exp_au, exp_dis, exp_sel});
            end
            checks++;
            if (au === 1'b1) q_au.push_back(i);
        end
        if (q_au.size() != 1 || q_au[0] != 7) begin
            errors++;
            $display("[TB] FAIL reset_release_schedule: au pulses=%0d expected 1 pulse at edge 7", q_au.size());
        end
        checks++;
        // Reset while the pulse is on the output must clear it at once
        reset = 1'b0;
        #1;
        if (au !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_during_pulse: au=%b expected=0", au);
        end
        checks++;
        aumentar = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            advance(1'b0, 1'b0, 1'b0);
            if ({au, dis, sel} !== {exp_au, exp_dis, exp_sel}) begin
                errors++;
                $display("[TB] FAIL reset_settle cycle %0d: outputs=%b expected=%b",
                         i, {au, dis, sel}, {exp_au, exp_dis, exp_sel});
            end
            checks++;
        end
    endtask

    task automatic test_random();
        int         rem [3] = '{0, 0, 0};
        logic [2:0] lvl = '0;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < 3; c++) begin
                if (rem[c] == 0) begin
                    lvl[c] = ~lvl[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 45))
                                                         : int'($urandom_range(1, 6));
                end
                rem[c]--;
            end
            advance(lvl[0], lvl[1], lvl[2]);
            if ({au, dis, sel} !== {exp_au, exp_dis, exp_sel}) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: outputs=%b expected=%b pins=%b",
                         i, {au, dis, sel}, {exp_au, exp_dis, exp_sel}, lvl);
            end
            checks++;
        end
        for (int i = 0; i < 30; i++) begin
            advance(1'b0, 1'b0, 1'b0);
            if ({au, dis, sel} !== {exp_au, exp_dis, exp_sel}) begin
                errors++;
                $display("[TB] FAIL random_drain cycle %0d: outputs=%b expected=%b",
                         i, {au, dis, sel}, {exp_au, exp_dis, exp_sel});
            end
            checks++;
        end
    endtask

    initial begin
        $display("[TB] acondicionador_botones bench start");
        test_reset();
        test_clean_press();
        test_bounce();
        test_auto_repeat();
        test_simultaneous();
        test_release_glitch();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
